// File: rtl/parser_conf_pkg.sv
// Shared definitions for the configuration-packet decoder at the parser ingress.
// Contents: packet-bus position tags, header/config field offsets, rule-address
// class codes, and the decoder state type.
package parser_conf_pkg;

  localparam int unsigned BUS_W = 134;

  // Position tag in bits [133:132] of each bus word
  localparam logic [1:0] TAG_BODY    = 2'b00;
  localparam logic [1:0] TAG_HEAD    = 2'b01;
  localparam logic [1:0] TAG_TAIL    = 2'b10;
  localparam logic [1:0] TAG_ILLEGAL = 2'b11;

  localparam int unsigned TAG_LSB    = 132;
  localparam int unsigned NIBBLE_LSB = 128;

  // Head-word fields
  localparam int unsigned DMAC_LSB  = 80;
  localparam int unsigned DMAC_W    = 48;
  localparam int unsigned ETYPE_LSB = 16;
  localparam int unsigned ETYPE_W   = 16;

  // Configuration-word fields
  localparam int unsigned CONF_DATA_LSB = 48;
  localparam int unsigned CONF_ADDR_LSB = 16;
  localparam int unsigned CONF_FIELD_W  = 32;

  // Rule-address decoding: bit 16 flags a type-offset config, [10:8] = class
  localparam int unsigned TYPE_OFFSET_BIT = 16;
  localparam logic [2:0] CLASS_RULES      = 3'd0;
  localparam logic [2:0] CLASS_TYPE_DATA  = 3'd1;
  localparam logic [2:0] CLASS_KEY_OFFSET = 3'd2;
  localparam logic [2:0] CLASS_HEAD_SHIFT = 3'd3;
  localparam logic [2:0] CLASS_META_SHIFT = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    CONF
  } state_t;

  function automatic logic [2:0] conf_class(input logic [31:0] addr);
    return addr[10:8];
  endfunction

endpackage

// File: rtl/conf_head_classifier.sv
// Combinational head classifier.
// Ports:
//   i_data  : 134-bit bus word
//   o_is_head : word carries the head position tag
//   o_is_conf : word is a head whose DMAC and ethertype mark a config packet
module conf_head_classifier
  import parser_conf_pkg::*;
#(
  parameter logic [47:0] CONF_DMAC  = 48'h8888_8888_8988,
  parameter logic [15:0] CONF_ETYPE = 16'h9006
) (
  input  logic [133:0] i_data,
  output logic         o_is_head,
  output logic         o_is_conf
);

  logic [1:0]  tag;
  logic [47:0] dmac;
  logic [15:0] etype;
  logic        unused_bits;

  assign tag   = i_data[TAG_LSB +: 2];
  assign dmac  = i_data[DMAC_LSB +: DMAC_W];
  assign etype = i_data[ETYPE_LSB +: ETYPE_W];

  assign o_is_head = (tag == TAG_HEAD);
  assign o_is_conf = o_is_head && (dmac == CONF_DMAC) && (etype == CONF_ETYPE);

  assign unused_bits = ^{i_data[131:128], i_data[79:32], i_data[15:0]};

endmodule

// File: rtl/conf_pkt_decoder.sv
// Configuration-packet decoder at the parser ingress.
// Forwards non-config packets one cycle later, bit-identical; consumes config
// packets and turns each valid config word into a one-cycle rule write.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_data_valid/i_data : 134-bit input bus (tag [133:132], nibble [131:128])
//   o_data_valid/o_data : forwarded bus
//   o_rule_wren/addr/wdata : rule-register write port (addr/data hold when idle)
//   o_cnt_conf_pkt      : completed config packets (saturating)
//   o_cnt_err           : malformed-stream events (saturating)
module conf_pkt_decoder
  import parser_conf_pkg::*;
#(
  parameter logic [47:0] CONF_DMAC  = 48'h8888_8888_8988,
  parameter logic [15:0] CONF_ETYPE = 16'h9006,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  input  logic [133:0]     i_data,
  output logic             o_data_valid,
  output logic [133:0]     o_data,
  output logic             o_rule_wren,
  output logic [31:0]      o_rule_addr,
  output logic [31:0]      o_rule_wdata,
  output logic [CNT_W-1:0] o_cnt_conf_pkt,
  output logic [CNT_W-1:0] o_cnt_err
);

  state_t             state_q, state_d;
  logic               data_valid_q, data_valid_d;
  logic [133:0]       data_q, data_d;
  logic               rule_wren_q, rule_wren_d;
  logic [31:0]        rule_addr_q, rule_addr_d;
  logic [31:0]        rule_wdata_q, rule_wdata_d;
  logic [CNT_W-1:0]   cnt_conf_q, cnt_conf_d;
  logic [CNT_W-1:0]   cnt_err_q, cnt_err_d;

  logic       is_head, is_conf;
  logic [1:0] tag;
  logic [3:0] nibble;
  logic       err_inc, conf_inc;

  assign tag    = i_data[TAG_LSB +: 2];
  assign nibble = i_data[NIBBLE_LSB +: 4];

  conf_head_classifier #(
    .CONF_DMAC  (CONF_DMAC),
    .CONF_ETYPE (CONF_ETYPE)
  ) u_classifier (
    .i_data    (i_data),
    .o_is_head (is_head),
    .o_is_conf (is_conf)
  );

  always_comb begin
    state_d      = state_q;
    data_valid_d = 1'b0;
    data_d       = data_q;
    rule_wren_d  = 1'b0;
    rule_addr_d  = rule_addr_q;
    rule_wdata_d = rule_wdata_q;
    err_inc      = 1'b0;
    conf_inc     = 1'b0;

    if (i_data_valid) begin
      if (is_head) begin
        // A head outside IDLE means the previous packet lost its tail; the
        // new head is classified immediately so no cycle is lost.
        if (state_q != IDLE) err_inc = 1'b1;
        if (is_conf) begin
          state_d = CONF;
        end else begin
          state_d      = FWD;
          data_valid_d = 1'b1;
          data_d       = i_data;
        end
      end else if (tag == TAG_ILLEGAL) begin
        err_inc = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: err_inc = 1'b1;
          FWD: begin
            data_valid_d = 1'b1;
            data_d       = i_data;
            if (tag == TAG_TAIL) state_d = IDLE;
          end
          CONF: begin
            if (nibble == 4'hf) begin
              rule_wren_d  = 1'b1;
              rule_addr_d  = i_data[CONF_ADDR_LSB +: CONF_FIELD_W];
              rule_wdata_d = i_data[CONF_DATA_LSB +: CONF_FIELD_W];
            end else begin
              err_inc = 1'b1;
            end
            if (tag == TAG_TAIL) begin
              conf_inc = 1'b1;
              state_d  = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    cnt_err_d  = (err_inc  && (cnt_err_q  != '1)) ? cnt_err_q  + 1'b1 : cnt_err_q;
    cnt_conf_d = (conf_inc && (cnt_conf_q != '1)) ? cnt_conf_q + 1'b1 : cnt_conf_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      rule_wren_q  <= 1'b0;
      rule_addr_q  <= '0;
      rule_wdata_q <= '0;
      cnt_conf_q   <= '0;
      cnt_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      rule_wren_q  <= rule_wren_d;
      rule_addr_q  <= rule_addr_d;
      rule_wdata_q <= rule_wdata_d;
      cnt_conf_q   <= cnt_conf_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign o_data_valid   = data_valid_q;
  assign o_data         = data_q;
  assign o_rule_wren    = rule_wren_q;
  assign o_rule_addr    = rule_addr_q;
  assign o_rule_wdata   = rule_wdata_q;
  assign o_cnt_conf_pkt = cnt_conf_q;
  assign o_cnt_err      = cnt_err_q;

endmodule

// File: tb/tb_conf_pkt_decoder.sv
module tb_conf_pkt_decoder;

  localparam logic [47:0] DMAC  = 48'h8888_8888_8988;
  localparam logic [15:0] ETYPE = 16'h9006;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic [133:0]  in_data = '0;
  logic          out_vld;
  logic [133:0]  out_data;
  logic          wren;
  logic [31:0]   waddr, wdata;
  logic [CW-1:0] cnt_conf, cnt_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conf_pkt_decoder #(
    .CONF_DMAC  (DMAC),
    .CONF_ETYPE (ETYPE),
    .CNT_W      (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_data_valid   (in_vld),
    .i_data         (in_data),
    .o_data_valid   (out_vld),
    .o_data         (out_data),
    .o_rule_wren    (wren),
    .o_rule_addr    (waddr),
    .o_rule_wdata   (wdata),
    .o_cnt_conf_pkt (cnt_conf),
    .o_cnt_err      (cnt_err)
  );

  // ---------------- word builders ----------------
  function automatic logic [133:0] mk_head(input logic [47:0] dmac, input logic [47:0] smac,
                                           input logic [15:0] et, input logic [15:0] rest);
    return {2'b01, 4'hf, dmac, smac, et, rest};
  endfunction

  function automatic logic [133:0] mk_conf(input logic [1:0] tag, input logic [3:0] nib,
                                           input logic [31:0] d, input logic [31:0] a);
    return {tag, nib, 48'h0, d, a, 16'h0};
  endfunction

  function automatic logic [133:0] mk_body(input logic [1:0] tag, input logic [127:0] p);
    return {tag, 4'hf, p};
  endfunction

  // ---------------- reference model ----------------
  // Packet context: 0 = between packets, 1 = inside normal packet, 2 = inside config packet
  int            m_ctx;
  logic          e_vld, e_wren;
  logic [133:0]  e_data;
  logic [31:0]   e_addr, e_wdata;
  int            e_err, e_conf;
  int            max_cnt = (1 << CW) - 1;

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_ctx = 0; e_vld = 0; e_wren = 0; e_data = '0;
    e_addr = '0; e_wdata = '0; e_err = 0; e_conf = 0;
  endtask

  task automatic model_step(input logic vld, input logic [133:0] d);
    logic [1:0] tag;
    bit         cfg;
    e_vld = 0; e_wren = 0;
    if (!vld) return;
    tag = d[133:132];
    cfg = (d[127:80] == DMAC) && (d[31:16] == ETYPE);
    if (tag == 2'b01) begin
      if (m_ctx != 0) e_err = sat_inc(e_err, max_cnt);
      if (cfg) m_ctx = 2;
      else begin m_ctx = 1; e_vld = 1; e_data = d; end
    end else if (tag == 2'b11) begin
      e_err = sat_inc(e_err, max_cnt); m_ctx = 0;
    end else if (m_ctx == 0) begin
      e_err = sat_inc(e_err, max_cnt);
    end else if (m_ctx == 1) begin
      e_vld = 1; e_data = d;
      if (tag == 2'b10) m_ctx = 0;
    end else begin
      if (d[131:128] == 4'hf) begin
        e_wren = 1; e_addr = d[47:16]; e_wdata = d[79:48];
      end else e_err = sat_inc(e_err, max_cnt);
      if (tag == 2'b10) begin e_conf = sat_inc(e_conf, max_cnt); m_ctx = 0; end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("data_valid", 134'(out_vld), 134'(e_vld));
    if (e_vld) chk("data", out_data, e_data);
    chk("rule_wren", 134'(wren), 134'(e_wren));
    chk("rule_addr", 134'(waddr), 134'(e_addr));
    chk("rule_wdata", 134'(wdata), 134'(e_wdata));
    chk("cnt_err", 134'(cnt_err), 134'(e_err));
    chk("cnt_conf", 134'(cnt_conf), 134'(e_conf));
  endtask

  task automatic check_all_zero(input string tagname);
    chk({tagname, "_vld"}, 134'(out_vld), '0);
    chk({tagname, "_data"}, out_data, '0);
    chk({tagname, "_wren"}, 134'(wren), '0);
    chk({tagname, "_addr"}, 134'(waddr), '0);
    chk({tagname, "_wdata"}, 134'(wdata), '0);
    chk({tagname, "_cerr"}, 134'(cnt_err), '0);
    chk({tagname, "_cconf"}, 134'(cnt_conf), '0);
  endtask

  task automatic step(input logic vld, input logic [133:0] d);
    @(negedge clk);
    in_vld = vld; in_data = d;
    model_step(vld, d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_vld = 0; in_data = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         vld;
    logic [133:0] d;
    logic         x_vld;
    logic         x_wren;
    logic [31:0]  x_addr;
    logic [31:0]  x_wdata;
    int           x_err;
    int           x_conf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [133:0] conf_hd;
    logic [133:0] w;
    int           wr_seen;

    model_reset();
    conf_hd = mk_head(DMAC, 48'h0000_0000_0001, ETYPE, 16'h0);

    // normal packet, config packet, stray body in IDLE, bad-nibble config word
    vecs.push_back('{1, mk_head(48'h0001_0203_0405, 48'h0607_0809_0a0b, 16'h0800, 16'h4500), 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, mk_body(2'b00, 128'd1), 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, mk_body(2'b00, 128'd2), 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, mk_body(2'b00, 128'd3), 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, mk_body(2'b10, 128'd4), 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, '0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, conf_hd, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, mk_conf(2'b00, 4'hf, 32'd1, 32'd0), 0, 1, 32'd0, 32'd1, 0, 0});
    vecs.push_back('{1, mk_conf(2'b10, 4'hf, 32'd3, 32'd1), 0, 1, 32'd1, 32'd3, 0, 1});
    vecs.push_back('{1, mk_body(2'b00, 128'hdead), 0, 0, 32'd1, 32'd3, 1, 1});
    vecs.push_back('{1, conf_hd, 0, 0, 32'd1, 32'd3, 1, 1});
    vecs.push_back('{1, mk_conf(2'b00, 4'h0, 32'h55, 32'h66), 0, 0, 32'd1, 32'd3, 2, 1});
    vecs.push_back('{0, '0, 0, 0, 32'd1, 32'd3, 2, 1});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vld, vecs[i].d);
      chk($sformatf("tbl%0d_vld", i), 134'(out_vld), 134'(vecs[i].x_vld));
      if (vecs[i].x_vld) chk($sformatf("tbl%0d_data", i), out_data, vecs[i].d);
      chk($sformatf("tbl%0d_wren", i), 134'(wren), 134'(vecs[i].x_wren));
      chk($sformatf("tbl%0d_addr", i), 134'(waddr), 134'(vecs[i].x_addr));
      chk($sformatf("tbl%0d_wdata", i), 134'(wdata), 134'(vecs[i].x_wdata));
      chk($sformatf("tbl%0d_err", i), 134'(cnt_err), 134'(vecs[i].x_err));
      chk($sformatf("tbl%0d_conf", i), 134'(cnt_conf), 134'(vecs[i].x_conf));
    end

    // key-offset config with 11 body/tail words, strobes back to back
    do_reset();
    wr_seen = 0;
    step(1, conf_hd);
    for (int i = 0; i < 11; i++) begin
      if (i < 9)       w = mk_conf(2'b00, 4'hf, 32'(i + 1), 32'h0001_0200 + 32'(i));
      else if (i == 9) w = mk_conf(2'b00, 4'hf, 32'd2, 32'h0001_0300);
      else             w = mk_conf(2'b10, 4'hf, 32'd0, 32'h0001_0400);
      step(1, w);
      if (wren) wr_seen++;
    end
    chk("keyoff_strobes", 134'(wr_seen), 134'd11);
    chk("keyoff_last_addr", 134'(waddr), 134'h0001_0400);
    chk("keyoff_conf", 134'(cnt_conf), 134'd1);

    // config head, then a normal head with no tail in between
    do_reset();
    step(1, conf_hd);
    step(1, mk_head(48'h0a0b_0c0d_0e0f, 48'h1, 16'h0800, 16'h4500));
    chk("miss_tail_err", 134'(cnt_err), 134'd1);
    step(1, mk_body(2'b00, 128'h77));
    step(1, mk_body(2'b10, 128'h78));
    chk("miss_tail_nowr", 134'(waddr), '0);

    // reset mid-config: two writes, then async reset mid-cycle
    do_reset();
    step(1, conf_hd);
    step(1, mk_conf(2'b00, 4'hf, 32'h11, 32'h21));
    step(1, mk_conf(2'b00, 4'hf, 32'h12, 32'h22));
    @(negedge clk);
    in_vld = 1; in_data = mk_conf(2'b00, 4'hf, 32'h13, 32'h23);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all_zero("midrst");
    @(posedge clk); #1;
    check_all_zero("midrst_hold");
    in_vld = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, mk_head(48'h0001_0203_0405, 48'h1, 16'h0800, 16'h0));
    step(1, mk_body(2'b10, 128'h99));
    step(0, '0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step(1, mk_body(2'b00, 128'(i)));
    chk("err_saturate", 134'(cnt_err), 134'(max_cnt));

    // randomized traffic against the model
    for (int blk = 0; blk < 30; blk++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        logic       v;
        logic [1:0] tg;
        logic [3:0] nb;
        int         r;
        v  = ($urandom_range(0, 9) < 8);
        r  = $urandom_range(0, 19);
        tg = (r < 4) ? 2'b01 : (r < 13) ? 2'b00 : (r < 19) ? 2'b10 : 2'b11;
        nb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hf;
        if (tg == 2'b01) begin
          if ($urandom_range(0, 1) == 1)
            w = mk_head(DMAC, {$urandom, 16'h0}, ($urandom_range(0, 5) == 0) ? 16'h9007 : ETYPE,
                        16'($urandom));
          else
            w = mk_head({$urandom, 16'($urandom)}, 48'h2, 16'h0800, 16'($urandom));
        end else begin
          w = {tg, nb, $urandom, $urandom, $urandom, $urandom};
        end
        step(v, w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
